// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline front end: reset constants, fetch FSM
// encodings and the IF/ID update selector used by the fetch stage.
package pipe_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    // What the IF/ID register does on the coming edge.
    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_MEM    = 2'd1,
        IFID_SKID   = 2'd2,
        IFID_BUBBLE = 2'd3
    } ifid_op_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {inst, pc4} holding slot for a word that arrives while ID is stalled.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc4,
    output logic [31:0] inst,
    output logic [31:0] pc4,
    output logic        full
);
    import pipe_pkg::*;

    fetch_entry_t entry;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

    // NOTE: the payload is not reset; it is only ever read while full is set,
    // and leaving it unreset keeps it a plain enable flop.
    always_ff @(posedge clk) begin
        if (load) begin
            entry <= '{inst: load_inst, pc4: load_pc4};
        end
    end

    assign inst = entry.inst;
    assign pc4  = entry.pc4;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register: drives the imem
// req/ready port, absorbs load-use stalls via a skid slot, handles redirects.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Load_Use,
    input  logic        Redirect,
    input  logic [31:0] Redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_inst,
    output logic [31:0] IF_ID_pc4,
    output logic        IF_ID_valid,
    output logic [4:0]  IF_ID_rs,
    output logic [4:0]  IF_ID_rt
);
    import pipe_pkg::*;

    fetch_state_e state, state_nxt;
    ifid_op_e     ifid_op;

    logic        started;
    logic [31:0] pc, pc_nxt;
    logic [31:0] tgt, tgt_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_aligned;
    logic        xfer;

    logic        skid_load, skid_unload, skid_clear;
    logic [31:0] skid_inst, skid_pc4;
    logic        skid_full;

    assign pc_plus4         = pc + 32'd4;
    assign redirect_aligned = word_align(Redirect_pc);
    assign xfer             = imem_req & imem_ready;

    // Held low for the first cycle out of reset so the request rises one clock
    // after rst_n deasserts, and drops immediately when reset is reasserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                if (xfer) begin
                    if (!Redirect && Load_Use) begin
                        state_nxt = HOLD;
                    end
                end else if (Redirect) begin
                    state_nxt = DISCARD;
                end
            end
            HOLD: begin
                if (Redirect || !Load_Use) begin
                    state_nxt = FETCH;
                end
            end
            DISCARD: begin
                if (xfer) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        imem_req  = started && (state != HOLD);
        imem_addr = pc;
    end

    // Datapath control: PC, latched redirect target, skid and IF/ID actions.
    always_comb begin
        pc_nxt      = pc;
        tgt_nxt     = tgt;
        ifid_op     = IFID_HOLD;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;
        case (state)
            FETCH: begin
                if (xfer) begin
                    if (Redirect) begin
                        pc_nxt  = redirect_aligned;
                        ifid_op = IFID_BUBBLE;
                    end else if (Load_Use) begin
                        pc_nxt    = pc_plus4;
                        skid_load = 1'b1;
                    end else begin
                        pc_nxt  = pc_plus4;
                        ifid_op = IFID_MEM;
                    end
                end else if (Redirect) begin
                    tgt_nxt = redirect_aligned;
                    ifid_op = IFID_BUBBLE;
                end else if (!Load_Use) begin
                    ifid_op = IFID_BUBBLE;
                end
            end
            HOLD: begin
                if (Redirect) begin
                    pc_nxt     = redirect_aligned;
                    skid_clear = 1'b1;
                    ifid_op    = IFID_BUBBLE;
                end else if (!Load_Use) begin
                    skid_unload = 1'b1;
                    ifid_op     = IFID_SKID;
                end
            end
            DISCARD: begin
                if (Redirect) begin
                    tgt_nxt = redirect_aligned;
                end
                if (xfer) begin
                    pc_nxt = Redirect ? redirect_aligned : tgt;
                end
                if (Redirect || !Load_Use) begin
                    ifid_op = IFID_BUBBLE;
                end
            end
            default: ifid_op = IFID_BUBBLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc  <= RESET_PC;
            tgt <= RESET_PC;
        end else begin
            pc  <= pc_nxt;
            tgt <= tgt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IF_ID_inst  <= NOP_INST;
            IF_ID_pc4   <= 32'd0;
            IF_ID_valid <= 1'b0;
        end else begin
            case (ifid_op)
                IFID_MEM: begin
                    IF_ID_inst  <= imem_rdata;
                    IF_ID_pc4   <= pc_plus4;
                    IF_ID_valid <= 1'b1;
                end
                IFID_SKID: begin
                    IF_ID_inst  <= skid_inst;
                    IF_ID_pc4   <= skid_pc4;
                    IF_ID_valid <= 1'b1;
                end
                IFID_BUBBLE: begin
                    IF_ID_inst  <= NOP_INST;
                    IF_ID_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .unload    (skid_unload),
        .clear     (skid_clear),
        .load_inst (imem_rdata),
        .load_pc4  (pc_plus4),
        .inst      (skid_inst),
        .pc4       (skid_pc4),
        .full      (skid_full)
    );

    // Occupancy follows the HOLD state by construction; the flag is kept for
    // debug visibility and tied off here.
    logic unused_skid_full;
    assign unused_skid_full = skid_full;

    assign IF_ID_rs = IF_ID_inst[25:21];
    assign IF_ID_rt = IF_ID_inst[20:16];

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus random
// stall/redirect/ready traffic, scored against a transaction-level model.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    localparam int M_RUN   = 0;
    localparam int M_STALL = 1;
    localparam int M_DROP  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Load_Use;
    logic        Redirect;
    logic [31:0] Redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_inst;
    logic [31:0] IF_ID_pc4;
    logic        IF_ID_valid;
    logic [4:0]  IF_ID_rs;
    logic [4:0]  IF_ID_rt;

    if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Load_Use    (Load_Use),
        .Redirect    (Redirect),
        .Redirect_pc (Redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .IF_ID_inst  (IF_ID_inst),
        .IF_ID_pc4   (IF_ID_pc4),
        .IF_ID_valid (IF_ID_valid),
        .IF_ID_rs    (IF_ID_rs),
        .IF_ID_rt    (IF_ID_rt)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    exp_t sb[$];

    // Reference model: the architectural fetch pointer, a queue holding the
    // word parked during a stall, and the expected IF/ID contents.
    logic [31:0] m_pc, m_tgt, m_inst, m_pc4;
    logic        m_valid, m_started;
    int          m_mode;
    logic [63:0] m_skid[$];

    task automatic model_reset();
        m_pc      = RST_PC;
        m_tgt     = RST_PC;
        m_started = 1'b0;
        m_mode    = M_RUN;
        m_skid.delete();
        m_inst    = NOP;
        m_pc4     = 32'd0;
        m_valid   = 1'b0;
    endtask

    task automatic bubble();
        m_inst  = NOP;
        m_valid = 1'b0;
    endtask

    task automatic deliver(input logic [31:0] inst, input logic [31:0] pc4);
        m_inst  = inst;
        m_pc4   = pc4;
        m_valid = 1'b1;
    endtask

    // Drive one cycle of inputs, advance the model across the coming edge,
    // and queue what the DUT must show after that edge.
    task automatic step(input logic lu, input logic rd, input logic [31:0] rpc, input logic rdy);
        logic        req, xfer;
        logic [31:0] word;
        logic [63:0] ent;
        exp_t        e;
        Load_Use    = lu;
        Redirect    = rd;
        Redirect_pc = rpc;
        imem_ready  = rdy;
        req  = m_started && (m_mode != M_STALL);
        xfer = req && rdy;
        word = mem_word(m_pc);
        if (m_mode == M_RUN) begin
            if (xfer) begin
                if (rd) begin
                    m_pc = rpc;
                    bubble();
                end else if (lu) begin
                    m_skid.push_back({word, m_pc + 32'd4});
                    m_mode = M_STALL;
                    m_pc   = m_pc + 32'd4;
                end else begin
                    deliver(word, m_pc + 32'd4);
                    m_pc = m_pc + 32'd4;
                end
            end else if (rd) begin
                m_tgt  = rpc;
                m_mode = M_DROP;
                bubble();
            end else if (!lu) begin
                bubble();
            end
        end else if (m_mode == M_STALL) begin
            if (rd) begin
                m_skid.delete();
                bubble();
                m_pc   = rpc;
                m_mode = M_RUN;
            end else if (!lu) begin
                ent = m_skid.pop_front();
                deliver(ent[63:32], ent[31:0]);
                m_mode = M_RUN;
            end
        end else begin
            if (rd) m_tgt = rpc;
            if (xfer) begin
                m_pc   = m_tgt;
                m_mode = M_RUN;
            end
            if (rd || !lu) bubble();
        end
        m_started = 1'b1;
        e.req   = (m_mode != M_STALL);
        e.addr  = m_pc;
        e.inst  = m_inst;
        e.pc4   = m_pc4;
        e.valid = m_valid;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compares the DUT outputs after every edge against the queue.
    always @(posedge clk) begin
        exp_t e;
        logic [31:0] einst;
        #1;
        if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            einst = e.inst;
            check("imem_req",    {31'd0, imem_req},    {31'd0, e.req});
            check("imem_addr",   imem_addr,            e.addr);
            check("IF_ID_valid", {31'd0, IF_ID_valid}, {31'd0, e.valid});
            check("IF_ID_inst",  IF_ID_inst,           einst);
            check("IF_ID_pc4",   IF_ID_pc4,            e.pc4);
            check("IF_ID_rs",    {27'd0, IF_ID_rs},    {27'd0, einst[25:21]});
            check("IF_ID_rt",    {27'd0, IF_ID_rt},    {27'd0, einst[20:16]});
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'd0, imem_req},    32'd0);
        check({tag, "_addr"},  imem_addr,            RST_PC);
        check({tag, "_inst"},  IF_ID_inst,           NOP);
        check({tag, "_pc4"},   IF_ID_pc4,            32'd0);
        check({tag, "_valid"}, {31'd0, IF_ID_valid}, 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        Load_Use    = 1'b0;
        Redirect    = 1'b0;
        Redirect_pc = 32'd0;
        imem_ready  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Straight-line fetch out of reset
        repeat (4) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Two-cycle load-use stall with ready high
        repeat (2) step(1'b1, 1'b0, 32'd0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect coinciding with a transfer
        step(1'b0, 1'b1, 32'h0000_3100, 1'b1);
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect while memory is not ready for three cycles
        step(1'b0, 1'b1, 32'h0000_3200, 1'b0);
        repeat (2) step(1'b0, 1'b0, 32'd0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect and Load_Use together: redirect wins, no stall
        step(1'b1, 1'b1, 32'h0000_3300, 1'b1);
        repeat (2) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect during a stall, then a second redirect while discarding
        step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_3400, 1'b1);
        step(1'b0, 1'b1, 32'h0000_3500, 1'b0);
        step(1'b0, 1'b1, 32'h0000_3600, 1'b0);
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1);

        // PC+4 wrap at the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (4) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Reset asserted mid-transfer (req high, ready low)
        step(1'b0, 1'b0, 32'd0, 1'b0);
        imem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb.delete();
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset_hold");
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0,
                 32'h0000_3000 + ($urandom_range(0, 255) << 2),
                 $urandom_range(0, 9) < 7);
        end

        @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
